// File: rtl/top.sv
// ----------------------------------------------------------------------------
// top -- execute-stage ALU of the CPU datapath
//
// Combines two 16-bit register operands under a 4-bit opcode and presents the
// result and flags from a single register stage, one clock after the operands
// are sampled. A new operation is accepted on every rising edge.
//
// Opcodes:
//   0 ADD   A+B+cin         8 SRA   A>>>sh (sign fill)
//   1 SUB   A-B-bin         9 ROL   rotate left by sh
//   2 AND   A&B            10 ROR   rotate right by sh
//   3 OR    A|B            11 INC   A+1
//   4 XOR   A^B            12 DEC   A-1
//   5 NOT   ~A             13 SLTU  A<B ? 1 : 0
//   6 SHL   A<<sh          14 MUL   low 16 bits of A*B (optional)
//   7 SHR   A>>sh          15 PASSB B
//   where sh = B[3:0].
//
// Configuration macro:
//   TOP_MUL_EN  when defined, opcode 14 multiplies; when undefined, the
//               multiplier is left out and opcode 14 returns zero.
//
// Ports:
//   clk      in   1   system clock, rising-edge active
//   rst_n    in   1   synchronous active-low reset
//   op_code  in   4   operation select
//   rs1_in   in  16   operand A
//   rs2_in   in  16   operand B
//   cin      in   1   carry-in (ADD only)
//   bin      in   1   borrow-in (SUB only)
//   result   out 16   registered result
//   flag_c   out  1   registered carry / borrow-out
//   flag_z   out  1   registered zero flag (result == 0)
// ----------------------------------------------------------------------------
module top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  op_code,
  input  logic [15:0] rs1_in,
  input  logic [15:0] rs2_in,
  input  logic        cin,
  input  logic        bin,
  output logic [15:0] result,
  output logic        flag_c,
  output logic        flag_z
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_SRA   = 4'd8,
    OP_ROL   = 4'd9,
    OP_ROR   = 4'd10,
    OP_INC   = 4'd11,
    OP_DEC   = 4'd12,
    OP_SLTU  = 4'd13,
    OP_MUL   = 4'd14,
    OP_PASSB = 4'd15
  } op_t;

  logic [3:0]  sh;
  logic [16:0] add_sum;
  logic [16:0] sub_diff;
  logic [16:0] inc_sum;
  logic [16:0] dec_diff;
  logic [15:0] shl_val;
  logic [15:0] shr_val;
  logic [15:0] sra_val;
  logic [15:0] rol_val;
  logic [15:0] ror_val;
  logic [15:0] mul_val;
  logic [15:0] next_result;
  logic        next_c;
  op_t         op;

  assign sh = rs2_in[3:0];
  assign op = op_t'(op_code);

  // Arithmetic is done 17 bits wide so bit 16 directly gives the carry (for
  // sums) or the borrow (for differences, where it becomes 1 on underflow).
  assign add_sum  = {1'b0, rs1_in} + {1'b0, rs2_in} + {16'd0, cin};
  assign sub_diff = {1'b0, rs1_in} - {1'b0, rs2_in} - {16'd0, bin};
  assign inc_sum  = {1'b0, rs1_in} + 17'd1;
  assign dec_diff = {1'b0, rs1_in} - 17'd1;

  // Plain and arithmetic shifts; a shift of zero leaves A untouched.
  assign shl_val = rs1_in << sh;
  assign shr_val = rs1_in >> sh;
  assign sra_val = $signed(rs1_in) >>> sh;

  // Rotates are built bit by bit with 4-bit index arithmetic, which wraps
  // modulo 16 for free and so needs no 32-bit doubled operand.
  always_comb begin
    rol_val = '0;
    ror_val = '0;
    for (int i = 0; i < 16; i++) begin
      rol_val[i] = rs1_in[4'(i) - sh];
      ror_val[i] = rs1_in[4'(i) + sh];
    end
  end

`ifdef TOP_MUL_EN
  // Only the low half of the product is ever needed, so the multiply is
  // evaluated at 16-bit width.
  assign mul_val = rs1_in * rs2_in;
`else
  assign mul_val = 16'h0000;
`endif

  // Opcode decode: selects the value and carry that will be registered.
  // Carry defaults to 0 so only the four arithmetic opcodes can set it.
  always_comb begin
    next_result = 16'h0000;
    next_c      = 1'b0;
    unique case (op)
      OP_ADD: begin
        next_result = add_sum[15:0];
        next_c      = add_sum[16];
      end
      OP_SUB: begin
        next_result = sub_diff[15:0];
        next_c      = sub_diff[16];
      end
      OP_AND:   next_result = rs1_in & rs2_in;
      OP_OR:    next_result = rs1_in | rs2_in;
      OP_XOR:   next_result = rs1_in ^ rs2_in;
      OP_NOT:   next_result = ~rs1_in;
      OP_SHL:   next_result = shl_val;
      OP_SHR:   next_result = shr_val;
      OP_SRA:   next_result = sra_val;
      OP_ROL:   next_result = rol_val;
      OP_ROR:   next_result = ror_val;
      OP_INC: begin
        next_result = inc_sum[15:0];
        next_c      = inc_sum[16];
      end
      OP_DEC: begin
        next_result = dec_diff[15:0];
        next_c      = dec_diff[16];
      end
      OP_SLTU:  next_result = (rs1_in < rs2_in) ? 16'd1 : 16'd0;
      OP_MUL:   next_result = mul_val;
      OP_PASSB: next_result = rs2_in;
      default: begin
        next_result = 16'h0000;
        next_c      = 1'b0;
      end
    endcase
  end

  // Single register stage. The zero flag is computed from the value being
  // loaded so it can never disagree with result. Reset wins over any
  // operation presented on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= 16'h0000;
      flag_c <= 1'b0;
      flag_z <= 1'b1;
    end else begin
      result <= next_result;
      flag_c <= next_c;
      flag_z <= (next_result == 16'h0000);
    end
  end

endmodule

// File: tb/tb_top.sv
// ----------------------------------------------------------------------------
// tb_top -- directed self-checking bench for the execute-stage ALU (top).
// Expected values are hand-computed constants. Build with +define+TOP_MUL_EN
// to exercise the multiplier variant.
// ----------------------------------------------------------------------------
module tb_top;

  logic        clk;
  logic        rst_n;
  logic [3:0]  op_code;
  logic [15:0] rs1_in;
  logic [15:0] rs2_in;
  logic        cin;
  logic        bin;
  logic [15:0] result;
  logic        flag_c;
  logic        flag_z;

  int errors;
  int checks;

  top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .op_code (op_code),
    .rs1_in  (rs1_in),
    .rs2_in  (rs2_in),
    .cin     (cin),
    .bin     (bin),
    .result  (result),
    .flag_c  (flag_c),
    .flag_z  (flag_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation, let one rising edge register it, then settle #1.
  task automatic drive_op(input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic ci, input logic bi);
    op_code = op;
    rs1_in  = a;
    rs2_in  = b;
    cin     = ci;
    bin     = bi;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive_op(4'd0, 16'd5, 16'd7, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (result !== 16'h0000 || flag_c !== 1'b0 || flag_z !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_state got r=%h c=%b z=%b want r=0000 c=0 z=1",
               result, flag_c, flag_z);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (result !== 16'd12 || flag_c !== 1'b0 || flag_z !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release got r=%h c=%b z=%b want r=000c c=0 z=0",
               result, flag_c, flag_z);
    end
  endtask

  task automatic test_and;
    drive_op(4'd2, 16'd6, 16'h4001, 1'b0, 1'b0);
    checks++;
    if (result !== 16'h0000 || flag_c !== 1'b0 || flag_z !== 1'b1) begin
      errors++;
      $display("[TB] FAIL and got r=%h c=%b z=%b want r=0000 c=0 z=1",
               result, flag_c, flag_z);
    end
  endtask

  task automatic test_carry_borrow;
    drive_op(4'd0, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    checks++;
    if (result !== 16'h0000 || flag_c !== 1'b1 || flag_z !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_carry got r=%h c=%b z=%b want r=0000 c=1 z=1",
               result, flag_c, flag_z);
    end
    drive_op(4'd1, 16'd3, 16'd3, 1'b0, 1'b1);
    checks++;
    if (result !== 16'hFFFF || flag_c !== 1'b1 || flag_z !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sub_borrow got r=%h c=%b z=%b want r=ffff c=1 z=0",
               result, flag_c, flag_z);
    end
    // cin must be ignored by SUB and bin by ADD.
    drive_op(4'd1, 16'd10, 16'd4, 1'b1, 1'b0);
    checks++;
    if (result !== 16'd6 || flag_c !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sub_ignores_cin got r=%h c=%b want r=0006 c=0",
               result, flag_c);
    end
    drive_op(4'd0, 16'd10, 16'd4, 1'b0, 1'b1);
    checks++;
    if (result !== 16'd14 || flag_c !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_ignores_bin got r=%h c=%b want r=000e c=0",
               result, flag_c);
    end
  endtask

  task automatic test_shifts;
    logic [15:0] exp_sh1 [5];
    exp_sh1[0] = 16'h0002;
    exp_sh1[1] = 16'h4000;
    exp_sh1[2] = 16'hC000;
    exp_sh1[3] = 16'h0003;
    exp_sh1[4] = 16'hC000;
    for (int k = 0; k < 5; k++) begin
      drive_op(4'(6 + k), 16'h8001, 16'h0001, 1'b1, 1'b1);
      checks++;
      if (result !== exp_sh1[k] || flag_c !== 1'b0) begin
        errors++;
        $display("[TB] FAIL shift_op%0d got r=%h c=%b want r=%h c=0",
                 6 + k, result, flag_c, exp_sh1[k]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      drive_op(4'(6 + k), 16'h8001, 16'h0010, 1'b0, 1'b0);
      checks++;
      if (result !== 16'h8001) begin
        errors++;
        $display("[TB] FAIL shift_zero_op%0d got r=%h want r=8001",
                 6 + k, result);
      end
    end
    // A multi-bit amount distinguishes the rotates from simple shifts.
    drive_op(4'd9, 16'h1234, 16'h0004, 1'b0, 1'b0);
    checks++;
    if (result !== 16'h2341) begin
      errors++;
      $display("[TB] FAIL rol4 got r=%h want r=2341", result);
    end
    drive_op(4'd10, 16'h1234, 16'h0004, 1'b0, 1'b0);
    checks++;
    if (result !== 16'h4123) begin
      errors++;
      $display("[TB] FAIL ror4 got r=%h want r=4123", result);
    end
  endtask

  task automatic test_misc;
    drive_op(4'd11, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    checks++;
    if (result !== 16'h0000 || flag_c !== 1'b1 || flag_z !== 1'b1) begin
      errors++;
      $display("[TB] FAIL inc_wrap got r=%h c=%b z=%b want r=0000 c=1 z=1",
               result, flag_c, flag_z);
    end
    drive_op(4'd11, 16'h0041, 16'h0000, 1'b0, 1'b0);
    checks++;
    if (result !== 16'h0042 || flag_c !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inc got r=%h c=%b want r=0042 c=0", result, flag_c);
    end
    drive_op(4'd12, 16'h0000, 16'h0000, 1'b0, 1'b0);
    checks++;
    if (result !== 16'hFFFF || flag_c !== 1'b1 || flag_z !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dec_wrap got r=%h c=%b z=%b want r=ffff c=1 z=0",
               result, flag_c, flag_z);
    end
    drive_op(4'd13, 16'd2, 16'd3, 1'b0, 1'b0);
    checks++;
    if (result !== 16'd1 || flag_z !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sltu_lt got r=%h z=%b want r=0001 z=0", result, flag_z);
    end
    drive_op(4'd13, 16'd3, 16'd2, 1'b0, 1'b0);
    checks++;
    if (result !== 16'd0 || flag_z !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sltu_ge got r=%h z=%b want r=0000 z=1", result, flag_z);
    end
    drive_op(4'd15, 16'hFFFF, 16'h1234, 1'b1, 1'b1);
    checks++;
    if (result !== 16'h1234 || flag_c !== 1'b0) begin
      errors++;
      $display("[TB] FAIL passb got r=%h c=%b want r=1234 c=0", result, flag_c);
    end
    drive_op(4'd5, 16'h00FF, 16'h0000, 1'b0, 1'b0);
    checks++;
    if (result !== 16'hFF00) begin
      errors++;
      $display("[TB] FAIL not got r=%h want r=ff00", result);
    end
  endtask

  task automatic test_mul;
    logic [15:0] exp_mul;
    logic        exp_z;
`ifdef TOP_MUL_EN
    exp_mul = 16'h5F90;
    exp_z   = 1'b0;
`else
    exp_mul = 16'h0000;
    exp_z   = 1'b1;
`endif
    drive_op(4'd14, 16'd300, 16'd300, 1'b1, 1'b1);
    checks++;
    if (result !== exp_mul || flag_c !== 1'b0 || flag_z !== exp_z) begin
      errors++;
      $display("[TB] FAIL mul got r=%h c=%b z=%b want r=%h c=0 z=%b",
               result, flag_c, flag_z, exp_mul, exp_z);
    end
  endtask

  // Inputs are changed to the next operation immediately after each edge, so
  // the outputs must still show the previous operation until the next edge.
  task automatic test_back_to_back;
    logic [3:0]  ops  [6];
    logic [15:0] as   [6];
    logic [15:0] bs   [6];
    logic [15:0] exps [6];
    ops[0] = 4'd0;  as[0] = 16'd1;     bs[0] = 16'd2;     exps[0] = 16'h0003;
    ops[1] = 4'd4;  as[1] = 16'hF0F0;  bs[1] = 16'h0FF0;  exps[1] = 16'hFF00;
    ops[2] = 4'd3;  as[2] = 16'h1200;  bs[2] = 16'h0034;  exps[2] = 16'h1234;
    ops[3] = 4'd6;  as[3] = 16'h0001;  bs[3] = 16'h0004;  exps[3] = 16'h0010;
    ops[4] = 4'd15; as[4] = 16'h0000;  bs[4] = 16'hABCD;  exps[4] = 16'hABCD;
    ops[5] = 4'd1;  as[5] = 16'd7;     bs[5] = 16'd2;     exps[5] = 16'h0005;
    op_code = ops[0]; rs1_in = as[0]; rs2_in = bs[0]; cin = 1'b0; bin = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (k < 5) begin
        op_code = ops[k+1];
        rs1_in  = as[k+1];
        rs2_in  = bs[k+1];
      end
      #1;
      checks++;
      if (result !== exps[k]) begin
        errors++;
        $display("[TB] FAIL b2b_%0d got r=%h want r=%h", k, result, exps[k]);
      end
    end
  endtask

  task automatic test_midstream_reset;
    drive_op(4'd15, 16'h0000, 16'h5555, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive_op(4'd0, 16'h0F00, 16'h00F0, 1'b1, 1'b0);
    checks++;
    if (result !== 16'h0000 || flag_c !== 1'b0 || flag_z !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midstream_reset got r=%h c=%b z=%b want r=0000 c=0 z=1",
               result, flag_c, flag_z);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (result !== 16'h0FF1 || flag_c !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_midstream_reset got r=%h c=%b want r=0ff1 c=0",
               result, flag_c);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    op_code = 4'd0;
    rs1_in  = 16'd0;
    rs2_in  = 16'd0;
    cin     = 1'b0;
    bin     = 1'b0;
    test_reset();
    test_and();
    test_carry_borrow();
    test_shifts();
    test_misc();
    test_mul();
    test_back_to_back();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
